// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: bus request/response, F/D payload,
// FSM state and next-PC select encoding.
package fetch_unit_pkg;

    localparam logic [63:0] PC_RESET = 64'h8000_0000;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_SEL_HOLD  = 2'd0,
        PC_SEL_INC   = 2'd1,
        PC_SEL_REDIR = 2'd2,
        PC_SEL_PEND  = 2'd3
    } pc_sel_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        logic        misalign;
    } fetch_data_t;

endpackage

// File: rtl/fetch_unit_pc_select.sv
// Next-PC mux: hold, sequential pc+4, live redirect target or latched pending target.
module fetch_unit_pc_select
    import fetch_unit_pkg::*;
(
    input  pc_sel_t     i_sel,
    input  logic [63:0] i_pc,
    input  logic [63:0] i_redirect_pc,
    input  logic [63:0] i_redir_pc,
    output logic [63:0] o_pc_nxt
);

    always_comb begin
        o_pc_nxt = i_pc;
        case (i_sel)
            PC_SEL_HOLD:  o_pc_nxt = i_pc;
            PC_SEL_INC:   o_pc_nxt = i_pc + 64'd4;
            PC_SEL_REDIR: o_pc_nxt = i_redirect_pc;
            PC_SEL_PEND:  o_pc_nxt = i_redir_pc;
            default:      o_pc_nxt = i_pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding ibus request, captured word held for the
// F/D register, wrong-path words (including in-flight ones) discarded on redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = PC_RESET
)
(
    input  logic         clk,
    input  logic         reset,
    output ibus_req_t    ireq,
    input  ibus_resp_t   iresp,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    input  logic         f_accept,
    output fetch_data_t  dataF_nxt,
    output logic         fetch_busy,
    output fetch_state_t o_dbg_state
);

    // Downstream handshake: dataF_nxt.valid is held high with stable payload until the
    // cycle f_accept=1 (or a redirect drops it); ireq holds valid/addr until data_ok.
    fetch_state_t r_state;
    logic [63:0]  r_pc;
    logic [31:0]  r_ibuf;
    logic         r_misalign;
    logic         r_redir_pend;
    logic [63:0]  r_redir_pc;

    fetch_state_t w_state_nxt;
    logic [31:0]  w_ibuf_nxt;
    logic         w_misalign_nxt;
    logic         w_pend_nxt;
    logic [63:0]  w_redir_pc_nxt;
    pc_sel_t      w_pc_sel;
    logic [63:0]  w_pc_nxt;
    logic         w_pc_misaligned;
    logic         w_req_valid;
    logic         w_unused_addr_ok;

    assign w_pc_misaligned  = (r_pc[1:0] != 2'b00);
    assign w_unused_addr_ok = iresp.addr_ok;

    always_comb begin
        w_state_nxt    = r_state;
        w_ibuf_nxt     = r_ibuf;
        w_misalign_nxt = r_misalign;
        w_pend_nxt     = r_redir_pend;
        w_redir_pc_nxt = r_redir_pc;
        w_pc_sel       = PC_SEL_HOLD;
        case (r_state)
            ST_FETCH: begin
                if (w_pc_misaligned) begin
                    // No bus access was made, so a redirect here can restart directly.
                    if (redirect_valid) begin
                        w_pc_sel = PC_SEL_REDIR;
                    end else begin
                        w_state_nxt    = ST_HOLD;
                        w_misalign_nxt = 1'b1;
                        w_ibuf_nxt     = 32'd0;
                    end
                end else if (iresp.data_ok) begin
                    if (redirect_valid) begin
                        w_pc_sel   = PC_SEL_REDIR;
                        w_pend_nxt = 1'b0;
                    end else if (r_redir_pend) begin
                        w_pc_sel   = PC_SEL_PEND;
                        w_pend_nxt = 1'b0;
                    end else begin
                        w_ibuf_nxt     = iresp.data;
                        w_misalign_nxt = 1'b0;
                        w_state_nxt    = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_pend_nxt     = 1'b1;
                    w_redir_pc_nxt = redirect_pc;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_pc_sel    = PC_SEL_REDIR;
                    w_state_nxt = ST_FETCH;
                end else if (f_accept) begin
                    w_pc_sel    = PC_SEL_INC;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    fetch_unit_pc_select u_pc_select (
        .i_sel         (w_pc_sel),
        .i_pc          (r_pc),
        .i_redirect_pc (redirect_pc),
        .i_redir_pc    (r_redir_pc),
        .o_pc_nxt      (w_pc_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_ibuf       <= 32'd0;
            r_misalign   <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= 64'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ibuf       <= w_ibuf_nxt;
            r_misalign   <= w_misalign_nxt;
            r_redir_pend <= w_pend_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
        end
    end

    // Outputs are gated by reset so they clear the instant reset asserts.
    assign w_req_valid = reset && (r_state == ST_FETCH) && !w_pc_misaligned;

    always_comb begin
        ireq.valid = w_req_valid;
        ireq.addr  = reset ? r_pc : 64'd0;
    end

    always_comb begin
        dataF_nxt = '0;
        if (reset && (r_state == ST_HOLD)) begin
            dataF_nxt.valid     = 1'b1;
            dataF_nxt.pc        = r_pc;
            dataF_nxt.raw_instr = r_ibuf;
            dataF_nxt.misalign  = r_misalign;
        end
    end

    assign fetch_busy  = w_req_valid && !iresp.data_ok;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a bench-side memory responder and an
// expected-output queue for presented instructions.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic         clk;
    logic         reset;
    ibus_req_t    ireq;
    ibus_resp_t   iresp;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic         f_accept;
    fetch_data_t  dataF_nxt;
    logic         fetch_busy;
    fetch_state_t dbg_state;

    int vectors = 0;
    int errs    = 0;
    logic [97:0] exp_q[$];

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .f_accept       (f_accept),
        .dataF_nxt      (dataF_nxt),
        .fetch_busy     (fetch_busy),
        .o_dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!ireq.valid && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk(tag, ireq.valid, 1'b1);
    endtask

    // Full fetch: data_ok after lat cycles, held hold cycles in HOLD, then accepted.
    task automatic fetch_ok(input logic [63:0] addr, input int lat, input int hold);
        logic [97:0] e;
        wait_req("req_valid");
        chk("req_addr", ireq.addr, addr);
        for (int i = 0; i < lat; i++) begin
            chk("busy_wait", fetch_busy, 1'b1);
            chk("no_out_wait", dataF_nxt.valid, 1'b0);
            tick();
            #1;
            chk("addr_stable", ireq.addr, addr);
        end
        iresp.data_ok = 1'b1;
        iresp.data    = word_of(addr);
        exp_q.push_back({1'b1, addr, word_of(addr), 1'b0});
        #1;
        chk("busy_dok", fetch_busy, 1'b0);
        tick();
        iresp.data_ok = 1'b0;
        iresp.data    = $urandom;
        #1;
        chk("sb_depth", exp_q.size(), 1);
        e = exp_q.pop_front();
        chk("dataF", dataF_nxt, e);
        chk("req_idle_hold", ireq.valid, 1'b0);
        for (int i = 0; i < hold; i++) begin
            tick();
            #1;
            chk("hold_stable", dataF_nxt, e);
            chk("hold_no_req", ireq.valid, 1'b0);
            chk("hold_busy", fetch_busy, 1'b0);
        end
        f_accept = 1'b1;
        tick();
        f_accept = 1'b0;
        #1;
    endtask

    initial begin
        logic [63:0] addr;
        logic [97:0] e;
        reset          = 1'b0;
        iresp          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        f_accept       = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_valid", ireq.valid, 1'b0);
        chk("rst_dataF", dataF_nxt, 98'd0);
        chk("rst_busy", fetch_busy, 1'b0);
        chk("rst_state", dbg_state, ST_FETCH);
        reset = 1'b1;

        // Sequential fetch with latency 2, then a 5-cycle stall in HOLD.
        fetch_ok(64'h8000_0000, 2, 0);
        fetch_ok(64'h8000_0004, 2, 0);
        fetch_ok(64'h8000_0008, 2, 5);
        fetch_ok(64'h8000_000C, 2, 0);

        addr = 64'h8000_0010;
        repeat (4) begin
            fetch_ok(addr, $urandom_range(0, 3), $urandom_range(0, 2));
            addr = addr + 64'd4;
        end

        // Redirect two cycles before data_ok of the in-flight request.
        wait_req("rd_req");
        chk("rd_addr", ireq.addr, addr);
        chk("rd_busy0", fetch_busy, 1'b1);
        tick(); #1;
        chk("rd_busy1", fetch_busy, 1'b1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        #1;
        chk("rd_busy2", fetch_busy, 1'b1);
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = {$urandom, $urandom};
        #1;
        chk("rd_busy3", fetch_busy, 1'b1);
        chk("rd_addr_stable", ireq.addr, addr);
        tick();
        iresp.data_ok = 1'b1;
        iresp.data    = word_of(addr);
        #1;
        chk("rd_busy_dok", fetch_busy, 1'b0);
        tick();
        iresp.data_ok = 1'b0;
        #1;
        chk("rd_dropped", dataF_nxt.valid, 1'b0);
        chk("rd_sb_empty", exp_q.size(), 0);
        chk("rd_new_req", ireq.valid, 1'b1);
        chk("rd_new_addr", ireq.addr, 64'h8000_0100);
        fetch_ok(64'h8000_0100, 1, 0);

        // Two redirects during one outstanding request: latest wins.
        wait_req("rr_req");
        chk("rr_addr", ireq.addr, 64'h8000_0104);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        #1;
        tick();
        redirect_pc    = 64'h8000_0300;
        #1;
        chk("rr_busy", fetch_busy, 1'b1);
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = {$urandom, $urandom};
        iresp.data_ok  = 1'b1;
        #1;
        tick();
        iresp.data_ok = 1'b0;
        #1;
        chk("rr_dropped", dataF_nxt.valid, 1'b0);
        chk("rr_new_addr", ireq.addr, 64'h8000_0300);
        fetch_ok(64'h8000_0300, 0, 0);

        // Redirect arriving in the same cycle as data_ok.
        wait_req("rs_req");
        iresp.data_ok  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0380;
        #1;
        tick();
        iresp.data_ok  = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rs_dropped", dataF_nxt.valid, 1'b0);
        chk("rs_new_addr", ireq.addr, 64'h8000_0380);
        fetch_ok(64'h8000_0380, 2, 0);

        // Redirect and accept in the same HOLD cycle.
        wait_req("ra_req");
        chk("ra_addr", ireq.addr, 64'h8000_0384);
        iresp.data_ok = 1'b1;
        iresp.data    = word_of(64'h8000_0384);
        exp_q.push_back({1'b1, 64'h8000_0384, word_of(64'h8000_0384), 1'b0});
        tick();
        iresp.data_ok = 1'b0;
        #1;
        e = exp_q.pop_front();
        chk("ra_dataF", dataF_nxt, e);
        f_accept       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0400;
        tick();
        f_accept       = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("ra_req_valid", ireq.valid, 1'b1);
        chk("ra_new_addr", ireq.addr, 64'h8000_0400);
        fetch_ok(64'h8000_0400, 1, 0);

        // Redirect from HOLD to a misaligned target.
        wait_req("ma_req");
        iresp.data_ok = 1'b1;
        iresp.data    = word_of(64'h8000_0404);
        tick();
        iresp.data_ok = 1'b0;
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("ma_no_req", ireq.valid, 1'b0);
        chk("ma_no_busy", fetch_busy, 1'b0);
        chk("ma_fetch_out", dataF_nxt.valid, 1'b0);
        exp_q.push_back({1'b1, 64'h8000_0102, 32'd0, 1'b1});
        tick(); #1;
        e = exp_q.pop_front();
        chk("ma_dataF", dataF_nxt, e);
        chk("ma_state", dbg_state, ST_HOLD);
        repeat (2) begin
            tick(); #1;
            chk("ma_stable", dataF_nxt, e);
            chk("ma_hold_no_req", ireq.valid, 1'b0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0500;
        f_accept       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        f_accept       = 1'b0;
        #1;
        fetch_ok(64'h8000_0500, 0, 0);

        // Reset asserted mid-request: outputs clear without a clock edge.
        #1;
        chk("mr_req_before", ireq.valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("mr_req_valid", ireq.valid, 1'b0);
        chk("mr_dataF", dataF_nxt, 98'd0);
        chk("mr_busy", fetch_busy, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mr_req_after", ireq.valid, 1'b1);
        chk("mr_addr_after", ireq.addr, RST_PC);
        fetch_ok(RST_PC, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
